// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready handshake: binary ops finish on the accept edge,
// decimal ADC/SBC take one nibble per cycle and shifts/rotates take one bit per cycle.
module seq_alu #(
    parameter int WIDTH = 8,
    parameter int SW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             overflow_in,
    input  logic             decimal,
    input  logic [SW-1:0]    shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             negative,
    output logic             overflow,
    output logic             zero,
    output logic             carry
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] OP_ADC = 4'd0;
    localparam logic [3:0] OP_SBC = 4'd1;
    localparam logic [3:0] OP_EOR = 4'd2;
    localparam logic [3:0] OP_ORA = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_INC = 4'd5;
    localparam logic [3:0] OP_DEC = 4'd6;
    localparam logic [3:0] OP_ROR = 4'd7;
    localparam logic [3:0] OP_ROL = 4'd8;
    localparam logic [3:0] OP_ASL = 4'd9;
    localparam logic [3:0] OP_LSR = 4'd10;
    localparam logic [SW-1:0] NIBBLES = SW'(WIDTH / 4);

    state_t           state;
    logic [SW-1:0]    cnt;
    logic [3:0]       op_r;
    logic             dec_r;
    logic [WIDTH-1:0] a_w, b_w;
    logic             accept;
    logic [SW-1:0]    steps;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] rf;
    logic             rc, rv;
    logic [4:0]       bstep;
    logic [WIDTH:0]   sstep;
    logic [WIDTH-1:0] nxt_f;
    logic             nxt_c;

    function automatic logic is_shift(input logic [3:0] o);
        return (o >= OP_ROR) && (o <= OP_LSR);
    endfunction

    // Returns {carry, value} after one bit of shift/rotate through carry.
    function automatic logic [WIDTH:0] shift_step(input logic [3:0] o, input logic c,
                                                   input logic [WIDTH-1:0] v);
        case (o)
            OP_ROL:  return {v[WIDTH-1], v[WIDTH-2:0], c};
            OP_ROR:  return {v[0], c, v[WIDTH-1:1]};
            OP_ASL:  return {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
            default: return {v[0], 1'b0, v[WIDTH-1:1]};
        endcase
    endfunction

    // Returns {carry, digit} for one BCD nibble; non-BCD digits use the same rule.
    function automatic logic [4:0] bcd_step(input logic sub, input logic [3:0] an,
                                            input logic [3:0] bn, input logic c);
        logic signed [5:0] t, u;
        if (sub) begin
            t = $signed({2'b00, an}) - $signed({2'b00, bn}) - $signed({5'b00000, ~c});
            u = t - 6'sd6;
            if (t < 6'sd0) return {1'b0, u[3:0]};
            else           return {1'b1, t[3:0]};
        end else begin
            t = $signed({2'b00, an}) + $signed({2'b00, bn}) + $signed({5'b00000, c});
            u = t + 6'sd6;
            if (t > 6'sd9) return {1'b1, u[3:0]};
            else           return {1'b0, t[3:0]};
        end
    endfunction

    assign in_ready  = ((state == IDLE) || ((state == DONE) && out_ready)) && reset_n;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);

    always_comb begin
        steps = '0;
        if (is_shift(op))
            steps = shamt;
        else if (decimal && ((op == OP_ADC) || (op == OP_SBC)))
            steps = NIBBLES;
    end

    // Single-cycle result, used whenever the op needs no iteration.
    always_comb begin
        sum = '0;
        rf  = a;
        rc  = carry_in;
        rv  = overflow_in;
        case (op)
            OP_ADC: begin
                sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
                rf  = sum[WIDTH-1:0];
                rc  = sum[WIDTH];
                rv  = (a[WIDTH-1] ^ rf[WIDTH-1]) & (b[WIDTH-1] ^ rf[WIDTH-1]);
            end
            OP_SBC: begin
                sum = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, ~carry_in};
                rf  = sum[WIDTH-1:0];
                rc  = ~sum[WIDTH];
                rv  = (a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ rf[WIDTH-1]);
            end
            OP_EOR: rf = a ^ b;
            OP_ORA: rf = a | b;
            OP_AND: begin
                rf = a & b;
                rv = rf[WIDTH-2];
            end
            OP_INC: rf = a + WIDTH'(1);
            OP_DEC: rf = a - WIDTH'(1);
            OP_ROR, OP_ROL, OP_ASL, OP_LSR: rf = b;
            default: rf = a;
        endcase
    end

    // Decimal results fill f from the top so the first nibble lands at the bottom.
    always_comb begin
        bstep = bcd_step(op_r == OP_SBC, a_w[3:0], b_w[3:0], carry);
        sstep = shift_step(op_r, carry, f);
        if (dec_r) begin
            nxt_c = bstep[4];
            nxt_f = {bstep[3:0], f[WIDTH-1:4]};
        end else begin
            nxt_c = sstep[WIDTH];
            nxt_f = sstep[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            f        <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            negative <= 1'b0;
            zero     <= 1'b0;
        end else if (accept) begin
            if (steps == '0) begin
                state    <= DONE;
                f        <= rf;
                carry    <= rc;
                overflow <= rv;
                negative <= rf[WIDTH-1];
                zero     <= (rf == '0);
            end else begin
                state    <= BUSY;
                cnt      <= steps;
                f        <= is_shift(op) ? b : '0;
                carry    <= carry_in;
                overflow <= overflow_in;
            end
        end else begin
            case (state)
                BUSY: begin
                    f     <= nxt_f;
                    carry <= nxt_c;
                    cnt   <= cnt - 1'b1;
                    if (cnt == SW'(1)) begin
                        state    <= DONE;
                        negative <= nxt_f[WIDTH-1];
                        zero     <= (nxt_f == '0);
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_r  <= op;
            dec_r <= decimal && ((op == OP_ADC) || (op == OP_SBC));
            a_w   <= a;
            b_w   <= b;
        end else if (state == BUSY) begin
            a_w <= a_w >> 4;
            b_w <= b_w >> 4;
        end
    end

endmodule
